// File: rtl/wrd_decision.sv
// Word-recognition decision stage: a sequential signed argmax over the class scores,
// then a threshold, a consecutive-win debounce and a holdoff that gate a one-cycle wake pulse.
module wrd_decision #(
  parameter int                     I_BW           = 24,
  parameter int                     NUM_CLASSES    = 3,
  parameter int                     WAKE_CLASS     = 1,
  parameter logic signed [I_BW-1:0] THRESHOLD      = '0,
  parameter int                     CONSEC_COUNT   = 2,
  parameter int                     HOLDOFF_CYCLES = 16,
  parameter int                     C_BW           = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CLASSES*I_BW-1:0] data_i,
  input  logic                        valid_i,
  input  logic                        last_i,
  output logic                        ready_o,
  output logic [C_BW-1:0]             class_o,
  output logic [I_BW-1:0]             score_o,
  output logic                        class_valid_o,
  output logic                        wake_o,
  output logic                        drop_o
);

  localparam int CB = (CONSEC_COUNT > 1) ? $clog2(CONSEC_COUNT) : 1;
  localparam int HB = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  localparam logic [C_BW-1:0] LAST_IDX     = C_BW'(NUM_CLASSES - 1);
  localparam logic [C_BW-1:0] WAKE_IDX     = C_BW'(WAKE_CLASS);
  localparam logic [CB-1:0]   CONSEC_LAST  = CB'(CONSEC_COUNT - 1);
  localparam logic [HB-1:0]   HOLDOFF_LOAD = HB'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_CLASSES*I_BW-1:0] vec_q, vec_d;
  logic [C_BW-1:0]            idx_q, idx_d;
  logic [C_BW-1:0]            best_idx_q, best_idx_d;
  logic signed [I_BW-1:0]     best_q, best_d;
  logic [C_BW-1:0]            class_q, class_d;
  logic [I_BW-1:0]            score_q, score_d;
  logic                       class_valid_q, class_valid_d;
  logic                       wake_q, wake_d;
  logic                       drop_q, drop_d;
  logic [CB-1:0]              consec_q, consec_d;
  logic [HB-1:0]              holdoff_q, holdoff_d;

  logic                       decide;
  logic [C_BW-1:0]            cand_idx;
  logic signed [I_BW-1:0]     cand_score;
  logic                       eligible;

  logic signed [I_BW-1:0]     score_w [NUM_CLASSES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
      assign score_w[gi] = vec_q[gi*I_BW +: I_BW];
    end
  endgenerate

  // End-of-packet framing is handled upstream; one valid arrives per packet.
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    idx_d         = idx_q;
    best_idx_d    = best_idx_q;
    best_d        = best_q;
    class_d       = class_q;
    score_d       = score_q;
    class_valid_d = 1'b0;
    wake_d        = 1'b0;
    drop_d        = drop_q;
    consec_d      = consec_q;
    holdoff_d     = (holdoff_q != '0) ? holdoff_q - HB'(1) : holdoff_q;
    decide        = 1'b0;
    cand_idx      = best_idx_q;
    cand_score    = best_q;
    eligible      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          vec_d      = data_i;
          best_d     = data_i[I_BW-1:0];
          best_idx_d = '0;
          idx_d      = C_BW'(1);
          if (NUM_CLASSES == 1) begin
            state_d    = ST_DONE;
            decide     = 1'b1;
            cand_idx   = '0;
            cand_score = data_i[I_BW-1:0];
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        // Strict compare so ties keep the lower index.
        if (score_w[idx_q] > best_q) begin
          best_d     = score_w[idx_q];
          best_idx_d = idx_q;
          cand_score = score_w[idx_q];
          cand_idx   = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          decide  = 1'b1;
        end else begin
          idx_d = idx_q + C_BW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (valid_i && (state_q != ST_IDLE)) begin
      drop_d = 1'b1;
    end

    // The decision is folded in on the edge entering DONE so its outputs show during DONE.
    if (decide) begin
      class_d       = cand_idx;
      score_d       = cand_score;
      class_valid_d = 1'b1;
      eligible      = (cand_idx == WAKE_IDX) && (cand_score >= THRESHOLD);
      if (holdoff_q != '0) begin
        consec_d = '0;
      end else if (eligible && (consec_q == CONSEC_LAST)) begin
        wake_d    = 1'b1;
        consec_d  = '0;
        holdoff_d = HOLDOFF_LOAD;
      end else if (eligible) begin
        consec_d = consec_q + CB'(1);
      end else begin
        consec_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      vec_q         <= '0;
      idx_q         <= '0;
      best_idx_q    <= '0;
      best_q        <= '0;
      class_q       <= '0;
      score_q       <= '0;
      class_valid_q <= 1'b0;
      wake_q        <= 1'b0;
      drop_q        <= 1'b0;
      consec_q      <= '0;
      holdoff_q     <= '0;
    end else begin
      state_q       <= state_d;
      vec_q         <= vec_d;
      idx_q         <= idx_d;
      best_idx_q    <= best_idx_d;
      best_q        <= best_d;
      class_q       <= class_d;
      score_q       <= score_d;
      class_valid_q <= class_valid_d;
      wake_q        <= wake_d;
      drop_q        <= drop_d;
      consec_q      <= consec_d;
      holdoff_q     <= holdoff_d;
    end
  end

  assign ready_o       = (state_q == ST_IDLE);
  assign class_o       = class_q;
  assign score_o       = score_q;
  assign class_valid_o = class_valid_q;
  assign wake_o        = wake_q;
  assign drop_o        = drop_q;

endmodule

// File: tb/tb_wrd_decision.sv
// Scoreboard bench for wrd_decision: the driver queues hand-computed decisions,
// a negedge monitor pops and compares them whenever class_valid_o pulses.
module tb_wrd_decision;

  localparam int I_BW = 24;
  localparam int N    = 3;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [N*I_BW-1:0]   data_i;
  logic                valid_i;
  logic                last_i;
  logic                ready_o;
  logic [1:0]          class_o;
  logic [I_BW-1:0]     score_o;
  logic                class_valid_o;
  logic                wake_o;
  logic                drop_o;

  wrd_decision #(
    .I_BW          (I_BW),
    .NUM_CLASSES   (N),
    .WAKE_CLASS    (1),
    .THRESHOLD     (24'sd50),
    .CONSEC_COUNT  (2),
    .HOLDOFF_CYCLES(16)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .last_i       (last_i),
    .ready_o      (ready_o),
    .class_o      (class_o),
    .score_o      (score_o),
    .class_valid_o(class_valid_o),
    .wake_o       (wake_o),
    .drop_o       (drop_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]             cls;
    logic signed [I_BW-1:0] score;
    logic                   wake;
    int                     due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every decision pulse must match the head of the queue, on time.
  always @(negedge clk_i) begin
    if (class_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_decision", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("decision cycle=%0d class=%0d score=%0d wake=%0d", cyc, class_o,
                 $signed(score_o), wake_o);
        chk("decision_latency", cyc, mon_e.due);
        chk("class_o", class_o, mon_e.cls);
        chk("score_o", $signed(score_o), mon_e.score);
        chk("wake_o", wake_o, mon_e.wake);
      end
    end else begin
      if (wake_o !== 1'b0 && rst_i === 1'b0) chk("wake_without_decision", wake_o, 0);
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("missing_decision", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic send(input logic signed [I_BW-1:0] s0, input logic signed [I_BW-1:0] s1,
                      input logic signed [I_BW-1:0] s2, input logic [1:0] ecls,
                      input logic signed [I_BW-1:0] escore, input logic ewake);
    chk("ready_before_send", ready_o, 1);
    data_i  = {s2, s1, s0};
    valid_i = 1'b1;
    exp_q.push_back(exp_t'{cls: ecls, score: escore, wake: ewake, due: cyc + 3});
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  // Captures a vector, then resets the DUT while it is scanning.
  task automatic send_then_reset(input logic signed [I_BW-1:0] s1);
    data_i  = {24'sd10, s1, 24'sd0};
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("ready_in_scan", ready_o, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("ready_after_midreset", ready_o, 1);
    chk("class_after_midreset", class_o, 0);
    chk("score_after_midreset", score_o, 0);
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    last_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_ready", ready_o, 1);
    chk("reset_class", class_o, 0);
    chk("reset_score", score_o, 0);
    chk("reset_class_valid", class_valid_o, 0);
    chk("reset_wake", wake_o, 0);
    chk("reset_drop", drop_o, 0);

    // Argmax with ties and negative scores
    send(-5, 100, 100, 1, 100, 0);
    send(-8, -3, -9, 1, -3, 0);
    send(30, 30, -1, 0, 30, 0);

    // Debounce fires on the second eligible decision, then holdoff blocks a third
    send(0, 60, 10, 1, 60, 0);
    send(0, 60, 10, 1, 60, 1);
    @(negedge clk_i);
    send(0, 60, 10, 1, 60, 0);

    // Holdoff expired: two more eligible decisions wake again
    repeat (20) @(negedge clk_i);
    send(0, 60, 10, 1, 60, 0);
    send(0, 60, 10, 1, 60, 1);

    // Mid-scan reset clears holdoff, so an immediate pair wakes
    send_then_reset(60);
    send(0, 60, 10, 1, 60, 0);
    send(0, 60, 10, 1, 60, 1);

    // Mid-scan reset clears a pending consecutive count
    repeat (20) @(negedge clk_i);
    send(0, 60, 10, 1, 60, 0);
    send_then_reset(60);
    send(0, 60, 10, 1, 60, 0);

    // Below threshold never wakes
    send(0, 40, 10, 1, 40, 0);
    send(0, 40, 10, 1, 40, 0);

    // A different winner breaks the run
    send(0, 60, 10, 1, 60, 0);
    send(0, 10, 70, 2, 70, 0);
    send(0, 60, 10, 1, 60, 0);
    chk("drop_before_drop_test", drop_o, 0);

    // Drop: a second valid one cycle after capture is ignored but flagged
    chk("ready_before_drop", ready_o, 1);
    data_i  = {24'sd20, 24'sd3, 24'sd7};
    valid_i = 1'b1;
    exp_q.push_back(exp_t'{cls: 2'd2, score: 24'sd20, wake: 1'b0, due: cyc + 3});
    @(negedge clk_i);
    data_i = {24'sd0, 24'sd99, 24'sd0};
    chk("ready_while_scanning", ready_o, 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("drop_set", drop_o, 1);
    repeat (2) @(negedge clk_i);
    send(0, 60, 10, 1, 60, 0);
    chk("drop_sticky", drop_o, 1);

    repeat (5) @(negedge clk_i);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
